// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite constants and load/store size types
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_DATA  = 2'd1,
    LSU_MISAL = 2'd2
  } lsu_state_t;

  // Size code 3 has no legal encoding, so it is reported like a misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic r;
    case (size)
      2'd0:    r = 1'b0;
      2'd1:    r = addr_lo[0];
      2'd2:    r = (addr_lo != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - load lane extraction with sign/zero extension
module lsu_load_align
  import ahb_pkg::*;
(
  input  logic [31:0] hrdata_i,
  input  logic [1:0]  addr_i,
  input  mem_size_t   size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed lane out of the bus word, then extend it to 32 bits.
  always_comb begin
    data_o = '0;
    byte_v = hrdata_i[{addr_i, 3'b000} +: 8];
    half_v = addr_i[1] ? hrdata_i[31:16] : hrdata_i[15:0];
    case (size_i)
      MEM_B:   data_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
      MEM_H:   data_o = {{16{~unsigned_i & half_v[15]}}, half_v};
      default: data_o = hrdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ahb_master.sv
// rtl/lsu_ahb_master.sv - pipelined AHB-Lite data-side master for core load/store
module lsu_ahb_master
  import ahb_pkg::*;
#(
  parameter logic [3:0] HPROT = 4'b0011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dmem_haddr,
  output logic [2:0]  dmem_hburst,
  output logic        dmem_hmastlock,
  output logic [3:0]  dmem_hprot,
  output logic [2:0]  dmem_hsize,
  output logic [1:0]  dmem_htrans,
  output logic [31:0] dmem_hwdata,
  output logic        dmem_hwrite,
  input  logic [31:0] dmem_hrdata,
  input  logic        dmem_hready,
  input  logic        dmem_hresp
);

  lsu_state_t  state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic [2:0]  hsize_q, hsize_d;
  logic        hwrite_q, hwrite_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  mem_size_t   size_q, size_d;
  logic        uns_q, uns_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;

  logic        misal;
  logic        data_done;
  logic        accept;
  logic        accept_ok;
  logic [31:0] load_data;

  assign misal     = is_misaligned(req_size, req_addr[1:0]);
  assign data_done = (state_q == LSU_DATA) && dmem_hready && !dmem_hresp;
  // A new address phase may only start while the bus is ready, which is why
  // acceptance in DATA hangs combinationally off hready.
  assign req_ready = !rst && ((state_q == LSU_IDLE) || data_done);
  assign accept    = req_valid && req_ready;
  assign accept_ok = accept && !misal;

  // Next-state and captured request fields for the upcoming data phase.
  always_comb begin
    state_d   = state_q;
    haddr_d   = haddr_q;
    hsize_d   = hsize_q;
    hwrite_d  = hwrite_q;
    addr_lo_d = addr_lo_q;
    size_d    = size_q;
    uns_d     = uns_q;
    write_d   = write_q;
    wdata_d   = wdata_q;

    case (state_q)
      LSU_IDLE: begin
        if (accept) state_d = misal ? LSU_MISAL : LSU_DATA;
      end
      LSU_DATA: begin
        if (dmem_hready) begin
          if (dmem_hresp)  state_d = LSU_IDLE;
          else if (accept) state_d = misal ? LSU_MISAL : LSU_DATA;
          else             state_d = LSU_IDLE;
        end
      end
      default: state_d = LSU_IDLE;
    endcase

    if (accept_ok) begin
      haddr_d   = req_addr;
      hsize_d   = {1'b0, req_size};
      hwrite_d  = req_write;
      addr_lo_d = req_addr[1:0];
      size_d    = mem_size_t'(req_size);
      uns_d     = req_unsigned;
      write_d   = req_write;
      wdata_d   = req_wdata;
    end
  end

  // State and data-phase registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LSU_IDLE;
      haddr_q   <= '0;
      hsize_q   <= '0;
      hwrite_q  <= 1'b0;
      addr_lo_q <= '0;
      size_q    <= MEM_B;
      uns_q     <= 1'b0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      haddr_q   <= haddr_d;
      hsize_q   <= hsize_d;
      hwrite_q  <= hwrite_d;
      addr_lo_q <= addr_lo_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
    end
  end

  // Address phase goes out in the acceptance cycle; otherwise controls hold.
  assign dmem_htrans    = accept_ok ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign dmem_haddr     = haddr_d;
  assign dmem_hsize     = hsize_d;
  assign dmem_hwrite    = hwrite_d;
  assign dmem_hburst    = 3'b000;
  assign dmem_hmastlock = 1'b0;
  assign dmem_hprot     = HPROT;

  // Replicate sub-word store data across all byte lanes.
  always_comb begin
    dmem_hwdata = wdata_q;
    case (size_q)
      MEM_B:   dmem_hwdata = {4{wdata_q[7:0]}};
      MEM_H:   dmem_hwdata = {2{wdata_q[15:0]}};
      default: dmem_hwdata = wdata_q;
    endcase
  end

  lsu_load_align u_load_align (
    .hrdata_i   (dmem_hrdata),
    .addr_i     (addr_lo_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  assign resp_valid = ((state_q == LSU_DATA) && dmem_hready) || (state_q == LSU_MISAL);
  assign resp_err   = ((state_q == LSU_DATA) && dmem_hready && dmem_hresp) || (state_q == LSU_MISAL);
  assign resp_rdata = (data_done && !write_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_lsu_ahb_master.sv
// tb/tb_lsu_ahb_master.sv - directed scoreboard bench for lsu_ahb_master
module tb_lsu_ahb_master;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] dmem_haddr, dmem_hwdata, dmem_hrdata;
  logic [2:0]  dmem_hburst, dmem_hsize;
  logic        dmem_hmastlock, dmem_hwrite, dmem_hready, dmem_hresp;
  logic [3:0]  dmem_hprot;
  logic [1:0]  dmem_htrans;

  always #5 clk = ~clk;

  lsu_ahb_master #(.HPROT(4'b0011)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dmem_haddr(dmem_haddr), .dmem_hburst(dmem_hburst),
    .dmem_hmastlock(dmem_hmastlock), .dmem_hprot(dmem_hprot), .dmem_hsize(dmem_hsize),
    .dmem_htrans(dmem_htrans), .dmem_hwdata(dmem_hwdata), .dmem_hwrite(dmem_hwrite),
    .dmem_hrdata(dmem_hrdata), .dmem_hready(dmem_hready), .dmem_hresp(dmem_hresp)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic err, input logic [31:0] rdata);
    exp_t e;
    e.err   = err;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Slave memory model: one word array, byte-lane writes from the data phase.
  logic [31:0] mem [0:255];
  logic        dph_valid, dph_write;
  logic [31:0] dph_addr;
  logic [2:0]  dph_size;
  logic [31:0] wmerge;

  function automatic bit lane_en(input logic [2:0] sz, input logic [1:0] a, input int b);
    case (sz)
      3'b000:  return b == int'(a);
      3'b001:  return (b / 2) == int'(a[1]);
      default: return 1'b1;
    endcase
  endfunction

  assign dmem_hrdata = dph_valid ? mem[dph_addr[9:2]] : 32'h0;

  always_comb begin
    wmerge = mem[dph_addr[9:2]];
    for (int b = 0; b < 4; b++)
      if (lane_en(dph_size, dph_addr[1:0], b)) wmerge[8*b +: 8] = dmem_hwdata[8*b +: 8];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dph_valid <= 1'b0;
    end else if (dmem_hready) begin
      if (dph_valid && dph_write && !dmem_hresp) mem[dph_addr[9:2]] <= wmerge;
      dph_valid <= (dmem_htrans == HTRANS_NONSEQ);
      dph_addr  <= dmem_haddr;
      dph_write <= dmem_hwrite;
      dph_size  <= dmem_hsize;
    end
  end

  // Response monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL resp_unexpected: observed rdata 0x%08h err %0b expected no response", resp_rdata, resp_err);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        chk("resp_rdata", resp_rdata, e.rdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
  endtask

  task automatic issue(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rd);
    step();
    set_req(w, sz, uns, a, wd);
    @(negedge clk);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    if (req_ready) push_exp(exp_err, exp_rd);
  endtask

  task automatic idle();
    step();
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    dmem_hready = 1'b1; dmem_hresp = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_htrans", {30'h0, dmem_htrans}, {30'h0, HTRANS_IDLE});
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_haddr", dmem_haddr, 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);

    // Word store then word load
    issue("sw1", 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 0, 32'h0);
    chk("sw1_htrans", {30'h0, dmem_htrans}, {30'h0, HTRANS_NONSEQ});
    chk("sw1_hsize", {29'h0, dmem_hsize}, 32'h2);
    chk("sw1_hwrite", {31'h0, dmem_hwrite}, 32'h1);
    chk("sw1_haddr", dmem_haddr, 32'h100);
    chk("sw1_hburst", {29'h0, dmem_hburst}, 32'h0);
    chk("sw1_hprot", {28'h0, dmem_hprot}, 32'h3);
    chk("sw1_hmastlock", {31'h0, dmem_hmastlock}, 32'h0);
    issue("lw1", 0, 2'd2, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    chk("lw1_hwdata", dmem_hwdata, 32'hDEADBEEF);
    chk("lw1_htrans", {30'h0, dmem_htrans}, {30'h0, HTRANS_NONSEQ});
    chk("lw1_hwrite", {31'h0, dmem_hwrite}, 32'h0);
    chk("sw1_resp_valid", {31'h0, resp_valid}, 32'h1);
    idle();
    chk("lw1_resp_valid", {31'h0, resp_valid}, 32'h1);
    chk("idle_htrans", {30'h0, dmem_htrans}, {30'h0, HTRANS_IDLE});
    idle();
    chk("quiet_resp_valid", {31'h0, resp_valid}, 32'h0);

    // Sub-word loads
    issue("sw2", 1, 2'd2, 0, 32'h100, 32'h80FF1234, 0, 32'h0);
    issue("lb", 0, 2'd0, 0, 32'h103, 32'h0, 0, 32'hFFFFFF80);
    issue("lbu", 0, 2'd0, 1, 32'h103, 32'h0, 0, 32'h00000080);
    issue("lh", 0, 2'd1, 0, 32'h102, 32'h0, 0, 32'hFFFF80FF);
    issue("lhu", 0, 2'd1, 1, 32'h100, 32'h0, 0, 32'h00001234);
    idle();
    idle();

    // Byte store with lane replication
    issue("sb", 1, 2'd0, 0, 32'h101, 32'hABCDEF55, 0, 32'h0);
    chk("sb_haddr", dmem_haddr, 32'h101);
    chk("sb_hsize", {29'h0, dmem_hsize}, 32'h0);
    issue("lw_sb", 0, 2'd2, 0, 32'h100, 32'h0, 0, 32'h80FF5534);
    chk("sb_hwdata", dmem_hwdata, 32'h55555555);
    idle();
    idle();

    issue("sw_104", 1, 2'd2, 0, 32'h104, 32'h11111111, 0, 32'h0);
    issue("sw_108", 1, 2'd2, 0, 32'h108, 32'h22222222, 0, 32'h0);
    idle();
    idle();

    // Three back-to-back loads
    issue("b2b0", 0, 2'd2, 0, 32'h100, 32'h0, 0, 32'h80FF5534);
    chk("b2b0_htrans", {30'h0, dmem_htrans}, {30'h0, HTRANS_NONSEQ});
    issue("b2b1", 0, 2'd2, 0, 32'h104, 32'h0, 0, 32'h11111111);
    chk("b2b1_htrans", {30'h0, dmem_htrans}, {30'h0, HTRANS_NONSEQ});
    chk("b2b1_resp_valid", {31'h0, resp_valid}, 32'h1);
    issue("b2b2", 0, 2'd2, 0, 32'h108, 32'h0, 0, 32'h22222222);
    chk("b2b2_htrans", {30'h0, dmem_htrans}, {30'h0, HTRANS_NONSEQ});
    chk("b2b2_resp_valid", {31'h0, resp_valid}, 32'h1);
    idle();
    chk("b2b3_resp_valid", {31'h0, resp_valid}, 32'h1);
    idle();
    chk("b2b4_resp_valid", {31'h0, resp_valid}, 32'h0);

    // Back-to-back with two wait states in the second data phase
    issue("w0", 0, 2'd2, 0, 32'h100, 32'h0, 0, 32'h80FF5534);
    issue("w1", 1, 2'd2, 0, 32'h10C, 32'h33333333, 0, 32'h0);
    chk("w1_resp_valid", {31'h0, resp_valid}, 32'h1);
    for (int k = 0; k < 2; k++) begin
      step();
      set_req(0, 2'd2, 0, 32'h10C, 32'h0);
      dmem_hready = 1'b0;
      @(negedge clk);
      chk("wait_req_ready", {31'h0, req_ready}, 32'h0);
      chk("wait_htrans", {30'h0, dmem_htrans}, {30'h0, HTRANS_IDLE});
      chk("wait_hwdata", dmem_hwdata, 32'h33333333);
      chk("wait_resp_valid", {31'h0, resp_valid}, 32'h0);
    end
    step();
    dmem_hready = 1'b1;
    @(negedge clk);
    chk("w2_ready", {31'h0, req_ready}, 32'h1);
    if (req_ready) push_exp(0, 32'h33333333);
    chk("w2_htrans", {30'h0, dmem_htrans}, {30'h0, HTRANS_NONSEQ});
    chk("w2_resp_valid", {31'h0, resp_valid}, 32'h1);
    idle();
    chk("w3_resp_valid", {31'h0, resp_valid}, 32'h1);
    idle();

    // Misaligned word load
    issue("mis", 0, 2'd2, 0, 32'h102, 32'h0, 1, 32'h0);
    chk("mis_htrans", {30'h0, dmem_htrans}, {30'h0, HTRANS_IDLE});
    idle();
    chk("mis_resp_valid", {31'h0, resp_valid}, 32'h1);
    chk("mis_resp_err", {31'h0, resp_err}, 32'h1);
    chk("mis_req_ready", {31'h0, req_ready}, 32'h0);
    idle();
    chk("mis_after_ready", {31'h0, req_ready}, 32'h1);
    chk("mis_after_resp", {31'h0, resp_valid}, 32'h0);

    // Two-cycle slave ERROR with a pending request
    issue("err_sw", 1, 2'd2, 0, 32'h200, 32'hAAAAAAAA, 1, 32'h0);
    chk("err_sw_htrans", {30'h0, dmem_htrans}, {30'h0, HTRANS_NONSEQ});
    step();
    set_req(0, 2'd2, 0, 32'h100, 32'h0);
    dmem_hready = 1'b0;
    dmem_hresp  = 1'b1;
    @(negedge clk);
    chk("err1_req_ready", {31'h0, req_ready}, 32'h0);
    chk("err1_htrans", {30'h0, dmem_htrans}, {30'h0, HTRANS_IDLE});
    chk("err1_resp_valid", {31'h0, resp_valid}, 32'h0);
    step();
    dmem_hready = 1'b1;
    @(negedge clk);
    chk("err2_req_ready", {31'h0, req_ready}, 32'h0);
    chk("err2_htrans", {30'h0, dmem_htrans}, {30'h0, HTRANS_IDLE});
    chk("err2_resp_valid", {31'h0, resp_valid}, 32'h1);
    chk("err2_resp_err", {31'h0, resp_err}, 32'h1);
    step();
    dmem_hresp = 1'b0;
    @(negedge clk);
    chk("err_pend_ready", {31'h0, req_ready}, 32'h1);
    if (req_ready) push_exp(0, 32'h80FF5534);
    chk("err_pend_htrans", {30'h0, dmem_htrans}, {30'h0, HTRANS_NONSEQ});
    chk("err_pend_haddr", dmem_haddr, 32'h100);
    idle();
    chk("err_pend_resp", {31'h0, resp_valid}, 32'h1);
    idle();

    // Reset while a data phase is stalled
    step();
    set_req(0, 2'd2, 0, 32'h100, 32'h0);
    @(negedge clk);
    chk("rd_ready", {31'h0, req_ready}, 32'h1);
    step();
    req_valid = 1'b0;
    dmem_hready = 1'b0;
    @(negedge clk);
    chk("rd_wait_resp", {31'h0, resp_valid}, 32'h0);
    #1;
    set_req(0, 2'd2, 0, 32'h104, 32'h0);
    rst = 1'b1;
    #1;
    chk("rd_htrans", {30'h0, dmem_htrans}, {30'h0, HTRANS_IDLE});
    chk("rd_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rd_req_ready", {31'h0, req_ready}, 32'h0);
    step();
    step();
    rst = 1'b0;
    req_valid = 1'b0;
    dmem_hready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rd_no_stale", {31'h0, resp_valid}, 32'h0);
    end
    issue("rd_lw", 0, 2'd2, 0, 32'h104, 32'h0, 0, 32'h11111111);
    idle();
    chk("rd_lw_resp", {31'h0, resp_valid}, 32'h1);
    idle();

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_ahb_master.md
Name: lsu_ahb_master

Overview:
- Data-side AHB-Lite master that converts single load/store requests from the core's memory stage into AHB-Lite SINGLE transfers on the dmem_* port.
- Directly feeds the dual-port memory's data interface.
- Performs store byte-lane replication, load lane extraction with sign/zero extension, wait-state stalling and error handling, including misaligned-access detection.
- Pipelined: the next address phase overlaps the current data phase, so back-to-back accesses give one response per cycle.

Parameters:
- HPROT, 4'b0011, constant value driven on dmem_hprot (data access, privileged)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  request accepted this cycle when both valid and ready are high
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response valid; one per accepted request, in order
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  bus ERROR or misaligned access
- dmem_haddr  out  32  AHB address
- dmem_hburst  out  3  constant 3'b000 (SINGLE)
- dmem_hmastlock  out  1  constant 0
- dmem_hprot  out  4  constant HPROT
- dmem_hsize  out  3  {1'b0, req_size}
- dmem_htrans  out  2  2'b10 (NONSEQ) or 2'b00 (IDLE)
- dmem_hwdata  out  32  store data, valid during the data phase
- dmem_hwrite  out  1  req_write
- dmem_hrdata  in  32  read data
- dmem_hready  in  1  transfer complete
- dmem_hresp  in  1  ERROR response

Behaviour:
- State machine with states IDLE, DATA and MISAL.
  - IDLE: no transfer outstanding.
  - DATA: an AHB data phase is in progress.
  - MISAL: a synthetic one-cycle error response is being returned.
- req_ready = !rst && (state==IDLE || (state==DATA && hready && !hresp)). It is 0 in MISAL.
  - Consequence: req_ready depends combinationally on hready. The slave's hready must not depend combinationally on htrans.
- Misaligned request: halfword with addr[0]=1, word with addr[1:0]!=0, or size 3.
- On acceptance of an aligned request:
  - Drive htrans=NONSEQ; haddr, hsize and hwrite come straight from the request.
  - Register addr[1:0], size, unsigned, write and wdata.
  - Next state is DATA.
- On acceptance of a misaligned request:
  - htrans stays IDLE.
  - Next state is MISAL.
- When no request is accepted, htrans=IDLE. haddr and the other control outputs hold their last values.
- A NONSEQ is only ever driven while hready=1, so every address phase completes in the cycle it is driven.
- hwdata is driven from the registered wdata during DATA:
  - byte: {4{b}}
  - half: {2{h}}
  - word: as is
  - hwdata is held stable across wait states.
- DATA with hready=0 and hresp=0: wait state. No response, no new request.
- DATA with hready=1 and hresp=0:
  - resp_valid=1 this cycle (combinational); resp_err=0.
  - Loads: select the lane by registered addr[1:0] and size, then sign- or zero-extend.
  - A new request may be accepted in the same cycle; the next state is DATA, MISAL or IDLE accordingly.
- DATA with hresp=1 and hready=0 (first ERROR cycle): req_ready=0, so htrans=IDLE.
- DATA with hresp=1 and hready=1 (second ERROR cycle):
  - resp_valid=1, resp_err=1, resp_rdata=0.
  - req_ready=0; next state is IDLE. This gives exactly one bubble.
- MISAL: resp_valid=1, resp_err=1, resp_rdata=0 for one cycle, then next state is IDLE.
- Latency: aligned accesses respond one cycle after acceptance plus any wait states. Misaligned accesses respond exactly one cycle after acceptance.
- Reset (asynchronous): state=IDLE; htrans=IDLE; resp_valid=0; resp_err=0; req_ready=0; haddr=0. Registered data-phase fields reset to 0.
- Reset mid-DATA: the outstanding transfer is abandoned and no response is produced.
- There is no burst, lock or unaligned splitting.

Decomposition:
- Shared package ahb_pkg:
  - htrans constants: HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10
  - hsize constants
  - mem_size_t enum: MEM_B, MEM_H, MEM_W
- Natural sub-module: lsu_load_align. It is combinational: hrdata, addr[1:0], size and unsigned in; extended 32-bit data out. It is reused by the future cache path.

Test Plan:
- Word store/load: sw 0xDEADBEEF @0x100, then lw @0x100. Expect NONSEQ with hsize=3'b010 and hwdata=0xDEADBEEF, then resp_rdata=0xDEADBEEF one cycle after acceptance, resp_err=0.
- Sub-word loads: after sw 0x80FF1234 @0x100:
  - lb @0x103 -> 0xFFFFFF80
  - lbu @0x103 -> 0x00000080
  - lh @0x102 -> 0xFFFF80FF
  - lhu @0x100 -> 0x00001234
- Byte store: sb 0x55 @0x101. Expect hwdata=0x55555555 and haddr=0x101; a following lw @0x100 returns 0x80FF5534.
- Back-to-back with wait states:
  - Three lw issued on consecutive cycles give three consecutive NONSEQs and three consecutive resp_valid pulses.
  - Hold hready=0 for 2 cycles in the second data phase: req_ready=0, htrans=IDLE, hwdata stable, and the responses shift by 2 cycles.
- Errors:
  - lw @0x102: no NONSEQ; resp_valid=1 and resp_err=1 next cycle.
  - Slave two-cycle ERROR on sw @0x200 with a request pending: htrans=IDLE in both ERROR cycles, resp_err=1 in the second cycle, and the pending request is accepted the cycle after.
- Reset in DATA: assert rst while hready=0. Outputs immediately show htrans=IDLE, resp_valid=0, req_ready=0; after release, no stale response appears and a new lw completes normally.
